// File: rtl/simd_instr_sequencer.sv
// Instruction sequencer for the IF stage of the 4-stage SIMD pipeline.
// Issues a buffered program in order, honours stall, then drains with NOPs.
module simd_instr_sequencer #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int IW    = 25,
   parameter int DRAIN = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          stall,
   output logic [IW-1:0] instr_out,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done
);

   localparam int CW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

   typedef enum logic [1:0] {stIdle, stRun, stDrain, stDone} seqState;

   seqState       state, nextState;
   logic [IW-1:0] progMem [DEPTH];
   logic [AW:0]   lenReg, lenClamped;
   logic [CW-1:0] drainCnt;
   logic [AW-1:0] pcNext;
   logic          lastInstr, canLoad;

   assign lenClamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
   assign lastInstr  = ({1'b0, pc} == (lenReg - (AW+1)'(1)));
   assign pcNext     = pc + AW'(1);
   assign canLoad    = (state == stIdle) || (state == stDone);

   // NOTE: the program buffer has no reset so it maps onto plain RAM and survives a reset.
   // The issue logic reads the pre-edge contents, giving read-before-write at a start edge.
   always_ff @(posedge clk) begin
      if (prog_we && canLoad && !reset)
         progMem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= stIdle;
      else       state <= nextState;
   end

   // NOTE: nextState takes its default first so no path through the case infers a latch.
   always_comb begin
      nextState = state;
      unique case (state)
         stIdle, stDone: if (start) nextState = (lenClamped == '0) ? stDone : stRun;
         stRun:          if (!stall && lastInstr) nextState = stDrain;
         stDrain:        if (!stall && drainCnt == CW'(1)) nextState = stDone;
         default:        nextState = stIdle;
      endcase
   end

   always_comb begin
      busy = (state == stRun) || (state == stDrain);
      done = (state == stDone);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_out   <= '0;
         instr_valid <= 1'b0;
         pc          <= '0;
         drainCnt    <= '0;
         lenReg      <= '0;
      end else begin
         unique case (state)
            stIdle, stDone: begin
               if (start) begin
                  lenReg <= lenClamped;
                  if (lenClamped != '0) begin
                     pc          <= '0;
                     instr_out   <= progMem[0];
                     instr_valid <= 1'b1;
                  end
               end
            end
            stRun: begin
               if (!stall) begin
                  if (lastInstr) begin
                     instr_out   <= '0;
                     instr_valid <= 1'b0;
                     drainCnt    <= CW'(DRAIN);
                  end else begin
                     pc        <= pcNext;
                     instr_out <= progMem[pcNext];
                  end
               end
            end
            stDrain: begin
               if (!stall) drainCnt <= drainCnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
